// File: rtl/issue_select.sv
// Issue select: 16-entry reservation station that accepts two dispatched
// micro-ops per cycle and captures operand wakeups from three result buses.
// Each cycle it issues the oldest ready entry to each of its three
// functional units (FU0/FU1 ALU, FU2 MEM) through registered outputs.
module issue_select #(
  parameter int RS_DEPTH = 16,
  parameter int PREG_W   = 6,
  parameter int DATA_W   = 32,
  parameter int ROB_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  disp_valid_1,
  input  logic [6:0]            disp_op_1,
  input  logic [2:0]            disp_func3_1,
  input  logic [6:0]            disp_func7_1,
  input  logic [PREG_W-1:0]     disp_pd_1,
  input  logic [PREG_W-1:0]     disp_ps1_1,
  input  logic [PREG_W-1:0]     disp_ps2_1,
  input  logic [DATA_W-1:0]     disp_src1_data_1,
  input  logic [DATA_W-1:0]     disp_src2_data_1,
  input  logic                  disp_src1_rdy_1,
  input  logic                  disp_src2_rdy_1,
  input  logic [1:0]            disp_fu_1,
  input  logic [ROB_W-1:0]      disp_rob_1,
  input  logic                  disp_valid_2,
  input  logic [6:0]            disp_op_2,
  input  logic [2:0]            disp_func3_2,
  input  logic [6:0]            disp_func7_2,
  input  logic [PREG_W-1:0]     disp_pd_2,
  input  logic [PREG_W-1:0]     disp_ps1_2,
  input  logic [PREG_W-1:0]     disp_ps2_2,
  input  logic [DATA_W-1:0]     disp_src1_data_2,
  input  logic [DATA_W-1:0]     disp_src2_data_2,
  input  logic                  disp_src1_rdy_2,
  input  logic                  disp_src2_rdy_2,
  input  logic [1:0]            disp_fu_2,
  input  logic [ROB_W-1:0]      disp_rob_2,
  output logic                  rs_full,
  output logic [4:0]            free_cnt,
  input  logic [2:0]            cdb_valid,
  input  logic [3*PREG_W-1:0]   cdb_preg,
  input  logic [3*DATA_W-1:0]   cdb_data,
  input  logic [2:0]            fu_ready,
  output logic [2:0]            iss_valid,
  output logic [3*7-1:0]        iss_op,
  output logic [3*3-1:0]        iss_func3,
  output logic [3*7-1:0]        iss_func7,
  output logic [3*PREG_W-1:0]   iss_pd,
  output logic [3*DATA_W-1:0]   iss_src1,
  output logic [3*DATA_W-1:0]   iss_src2,
  output logic [3*ROB_W-1:0]    iss_rob
);
  localparam int IDX_W = $clog2(RS_DEPTH);
  localparam int NFU   = 3;

  typedef struct packed {
    logic [6:0]        op;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [PREG_W-1:0] pd;
    logic [PREG_W-1:0] ps1;
    logic [PREG_W-1:0] ps2;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic              rdy1;
    logic              rdy2;
    logic [1:0]        fu;
    logic [ROB_W-1:0]  rob;
  } entry_t;

  // Only the fields an FU consumes travel through the issue registers.
  typedef struct packed {
    logic [6:0]        op;
    logic [2:0]        func3;
    logic [6:0]        func7;
    logic [PREG_W-1:0] pd;
    logic [DATA_W-1:0] src1;
    logic [DATA_W-1:0] src2;
    logic [ROB_W-1:0]  rob;
  } issue_t;

  logic [RS_DEPTH-1:0] valid_q, valid_d;
  logic [4:0]          age_q [RS_DEPTH];
  logic [4:0]          age_d [RS_DEPTH];
  entry_t              ent_q [RS_DEPTH];
  entry_t              ent_d [RS_DEPTH];
  logic [4:0]          free_cnt_q, free_cnt_d;
  logic                rs_full_q, rs_full_d;
  logic [IDX_W-1:0]    sel_idx [NFU];
  logic [NFU-1:0]      issue_en;
  logic [RS_DEPTH-1:0] issued;
  logic                iss_vld_q [NFU];
  issue_t              iss_pl_q [NFU];
  entry_t              disp_ent_1, disp_ent_2;

  assign disp_ent_1 = '{op: disp_op_1, func3: disp_func3_1, func7: disp_func7_1, pd: disp_pd_1,
                        ps1: disp_ps1_1, ps2: disp_ps2_1, src1: disp_src1_data_1,
                        src2: disp_src2_data_1, rdy1: disp_src1_rdy_1, rdy2: disp_src2_rdy_1,
                        fu: disp_fu_1, rob: disp_rob_1};
  assign disp_ent_2 = '{op: disp_op_2, func3: disp_func3_2, func7: disp_func7_2, pd: disp_pd_2,
                        ps1: disp_ps1_2, ps2: disp_ps2_2, src1: disp_src1_data_2,
                        src2: disp_src2_data_2, rdy1: disp_src1_rdy_2, rdy2: disp_src2_rdy_2,
                        fu: disp_fu_2, rob: disp_rob_2};

  // Capture any matching broadcast into a not-yet-ready operand. Later buses
  // overwrite earlier ones, so the highest bus index wins a duplicate tag.
  // Tag 0 is the hard-wired zero register and never waits on a broadcast.
  function automatic entry_t wake(input entry_t e, input logic [NFU-1:0] v,
                                  input logic [NFU*PREG_W-1:0] tag,
                                  input logic [NFU*DATA_W-1:0] data);
    entry_t r;
    r = e;
    for (int k = 0; k < NFU; k++) begin
      if (v[k] && !e.rdy1 && e.ps1 != '0 && tag[k*PREG_W +: PREG_W] == e.ps1) begin
        r.rdy1 = 1'b1;
        r.src1 = data[k*DATA_W +: DATA_W];
      end
      if (v[k] && !e.rdy2 && e.ps2 != '0 && tag[k*PREG_W +: PREG_W] == e.ps2) begin
        r.rdy2 = 1'b1;
        r.src2 = data[k*DATA_W +: DATA_W];
      end
    end
    return r;
  endfunction

  // Per FU, pick the oldest fully-ready entry; strict '>' keeps the lowest index on a tie.
  always_comb begin
    logic             found;
    logic [IDX_W-1:0] best;
    issue_en = '0;
    issued   = '0;
    for (int k = 0; k < NFU; k++) begin
      found = 1'b0;
      best  = '0;
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (valid_q[i] && ent_q[i].fu == 2'(k) && ent_q[i].rdy1 && ent_q[i].rdy2 &&
            (!found || age_q[i] > age_q[best])) begin
          found = 1'b1;
          best  = IDX_W'(i);
        end
      end
      sel_idx[k]  = best;
      issue_en[k] = found && fu_ready[k];
      if (issue_en[k]) issued[best] = 1'b1;
    end
  end

  // Next RS state: retire issued entries, wake and age the rest, then allocate
  // dispatched ops into slots that were already free before this edge.
  always_comb begin
    int               nfree;
    int               cnt;
    logic [IDX_W-1:0] free0, free1, slot2;
    valid_d = valid_q;
    for (int i = 0; i < RS_DEPTH; i++) begin
      age_d[i] = age_q[i];
      ent_d[i] = ent_q[i];
    end
    nfree = 0;
    free0 = '0;
    free1 = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (!valid_q[i]) begin
        if (nfree == 0) free0 = IDX_W'(i);
        else if (nfree == 1) free1 = IDX_W'(i);
        nfree = nfree + 1;
      end
    end
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (valid_q[i]) begin
        if (issued[i]) begin
          valid_d[i] = 1'b0;
        end else begin
          ent_d[i] = wake(ent_q[i], cdb_valid, cdb_preg, cdb_data);
          age_d[i] = (age_q[i] == 5'd31) ? age_q[i] : age_q[i] + 5'd1;
        end
      end
    end
    slot2 = disp_valid_1 ? free1 : free0;
    if (!rs_full_q) begin
      if (disp_valid_1) begin
        valid_d[free0] = 1'b1;
        age_d[free0]   = '0;
        ent_d[free0]   = wake(disp_ent_1, cdb_valid, cdb_preg, cdb_data);
      end
      if (disp_valid_2) begin
        valid_d[slot2] = 1'b1;
        age_d[slot2]   = '0;
        ent_d[slot2]   = wake(disp_ent_2, cdb_valid, cdb_preg, cdb_data);
      end
    end
    cnt = 0;
    for (int i = 0; i < RS_DEPTH; i++) cnt = cnt + int'(valid_d[i]);
    free_cnt_d = 5'(RS_DEPTH - cnt);
    rs_full_d  = (free_cnt_d < 5'd2);
  end

  // Control state: entry valid bits, ages and the occupancy flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q    <= '0;
      free_cnt_q <= 5'(RS_DEPTH);
      rs_full_q  <= 1'b0;
      for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= '0;
    end else begin
      valid_q    <= valid_d;
      free_cnt_q <= free_cnt_d;
      rs_full_q  <= rs_full_d;
      for (int i = 0; i < RS_DEPTH; i++) age_q[i] <= age_d[i];
    end
  end

  // Entry payload; meaningless while the entry is invalid, so it needs no reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < RS_DEPTH; i++) ent_q[i] <= ent_d[i];
  end

  assign free_cnt = free_cnt_q;
  assign rs_full  = rs_full_q;

  for (genvar gi = 0; gi < NFU; gi++) begin : g_fu
    // Register the selected entry towards FU gi; the payload holds when idle.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        iss_vld_q[gi] <= 1'b0;
        iss_pl_q[gi]  <= '0;
      end else begin
        iss_vld_q[gi] <= issue_en[gi];
        if (issue_en[gi]) begin
          iss_pl_q[gi] <= '{op: ent_q[sel_idx[gi]].op, func3: ent_q[sel_idx[gi]].func3,
                            func7: ent_q[sel_idx[gi]].func7, pd: ent_q[sel_idx[gi]].pd,
                            src1: ent_q[sel_idx[gi]].src1, src2: ent_q[sel_idx[gi]].src2,
                            rob: ent_q[sel_idx[gi]].rob};
        end
      end
    end
    assign iss_valid[gi]                  = iss_vld_q[gi];
    assign iss_op[gi*7 +: 7]              = iss_pl_q[gi].op;
    assign iss_func3[gi*3 +: 3]           = iss_pl_q[gi].func3;
    assign iss_func7[gi*7 +: 7]           = iss_pl_q[gi].func7;
    assign iss_pd[gi*PREG_W +: PREG_W]    = iss_pl_q[gi].pd;
    assign iss_src1[gi*DATA_W +: DATA_W]  = iss_pl_q[gi].src1;
    assign iss_src2[gi*DATA_W +: DATA_W]  = iss_pl_q[gi].src2;
    assign iss_rob[gi*ROB_W +: ROB_W]     = iss_pl_q[gi].rob;
  end

endmodule
